// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] pc;
    logic [DEFAULT_WIDTH-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-decode FIFO: registered-only ready, head presented combinationally,
// flush on redirect, and a held copy of the last head while empty.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_pc,
  input  logic [WIDTH-1:0]         in_instr,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_pc,
  output logic [WIDTH-1:0]         out_pcplus4,
  output logic [WIDTH-1:0]         out_instr,
  output logic                     out_misaligned,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  fetch_entry_t           mem [DEPTH];
  fetch_entry_t           last_reg;
  fetch_entry_t           head;
  fetch_entry_t           shown;
  fetch_entry_t           wr_entry;
  logic [PTR_W-1:0]       wr_ptr_reg;
  logic [PTR_W-1:0]       rd_ptr_reg;
  logic [CNT_W-1:0]       count_reg;
  logic                   push;
  logic                   pop;

  assign in_ready  = (count_reg != CNT_W'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;
  assign count     = count_reg;

  // Entry fields are sized by the package width; narrower WIDTH values are zero-extended.
  assign wr_entry.pc    = DEFAULT_WIDTH'(in_pc);
  assign wr_entry.instr = DEFAULT_WIDTH'(in_instr);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
      else if (pop && !push) count_reg <= count_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push) begin
      mem[wr_ptr_reg] <= wr_entry;
    end
  end

  // Remember the most recent head so outputs stay stable once the queue drains.
  always_ff @(posedge clk) begin
    if (rst)            last_reg <= '0;
    else if (out_valid) last_reg <= head;
  end

  assign head  = mem[rd_ptr_reg];
  assign shown = out_valid ? head : last_reg;

  assign out_pc         = WIDTH'(shown.pc);
  assign out_instr      = WIDTH'(shown.instr);
  assign out_pcplus4    = out_pc + WIDTH'(4);
  assign out_misaligned = |out_pc[1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed scenarios plus a randomized run
// against a queue-based reference model.
module tb_fetch_queue;

  localparam int WIDTH = 32;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, out_ready;
  logic [WIDTH-1:0] in_pc, in_instr;
  logic             in_ready, out_valid, out_misaligned;
  logic [WIDTH-1:0] out_pc, out_pcplus4, out_instr;
  logic [2:0]       count;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  ent_t mq[$];
  ent_t last_head;

  fetch_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .in_pc(in_pc), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_pc(out_pc), .out_pcplus4(out_pcplus4),
    .out_instr(out_instr), .out_misaligned(out_misaligned),
    .out_ready(out_ready), .count(count)
  );

  always #5 clk = ~clk;

  // One clock edge; the reference model applies the queue rules to the inputs
  // held across that edge, then outputs are sampled 1 time unit later.
  task automatic step();
    bit do_push, do_pop;
    do_push = in_valid && (mq.size() < DEPTH) && !flush && !rst;
    do_pop  = (mq.size() > 0) && out_ready && !flush && !rst;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      last_head = '{pc: 32'h0, instr: 32'h0};
    end else begin
      if (mq.size() > 0) last_head = mq[0];
      if (flush) mq.delete();
      else begin
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back('{pc: in_pc, instr: in_instr});
      end
    end
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; flush = 0; in_valid = 0; out_ready = 0;
    in_pc = '0; in_instr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", count); end
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc got=%h want=0", out_pc); end
    checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_out_instr got=%h want=0", out_instr); end
    checks++; if (out_pcplus4 !== 32'h4) begin failures++; $display("FAIL reset_pcplus4 got=%h want=4", out_pcplus4); end
    $display("test_reset done");
  endtask

  task automatic test_fill_drain();
    logic [31:0] instrs [4];
    do_reset();
    for (int i = 0; i < 4; i++) instrs[i] = $urandom;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_pc = 32'(i * 4); in_instr = instrs[i];
      step();
    end
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL fill3_count got=%0d want=3", count); end
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL fill3_out_pc got=%h want=0", out_pc); end
    checks++; if (out_pcplus4 !== 32'h4) begin failures++; $display("FAIL fill3_pcplus4 got=%h want=4", out_pcplus4); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fill3_in_ready got=%b want=1", in_ready); end
    in_pc = 32'hC; in_instr = instrs[3];
    step();
    in_pc = 32'h10; in_instr = 32'hDEADBEEF;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_in_ready got=%b want=0", in_ready); end
      checks++; if (count !== 3'd4) begin failures++; $display("FAIL full_count got=%0d want=4", count); end
    end
    // First pop happens with in_valid still high at full: the push must be refused.
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_pc !== 32'(i * 4)) begin failures++; $display("FAIL drain_order got=%h want=%h", out_pc, 32'(i * 4)); end
      checks++; if (out_instr !== instrs[i]) begin failures++; $display("FAIL drain_instr got=%h want=%h", out_instr, instrs[i]); end
      step();
      in_valid = 0;
      checks++; if (count !== 3'(3 - i)) begin failures++; $display("FAIL drain_count got=%0d want=%0d", count, 3 - i); end
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL drain_out_valid got=%b want=0", out_valid); end
    checks++; if (out_pc !== 32'hC) begin failures++; $display("FAIL drain_hold_pc got=%h want=c", out_pc); end
    step();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL empty_pop_count got=%0d want=0", count); end
    out_ready = 0;
    $display("test_fill_drain done");
  endtask

  task automatic test_back_to_back();
    logic [31:0] next_push, next_pop;
    do_reset();
    next_push = 32'h200; next_pop = 32'h200;
    in_valid = 1;
    for (int i = 0; i < 2; i++) begin
      in_pc = next_push; in_instr = $urandom; next_push += 4;
      step();
    end
    out_ready = 1;
    for (int i = 0; i < 10; i++) begin
      checks++; if (out_pc !== next_pop) begin failures++; $display("FAIL b2b_out_pc got=%h want=%h", out_pc, next_pop); end
      in_pc = next_push; in_instr = $urandom; next_push += 4; next_pop += 4;
      step();
      checks++; if (count !== 3'd2) begin failures++; $display("FAIL b2b_count got=%0d want=2", count); end
    end
    idle_inputs();
    $display("test_back_to_back done");
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      in_pc = 32'(i * 4); in_instr = $urandom;
      step();
    end
    flush = 1; out_ready = 1; in_pc = 32'h50;
    step();
    flush = 0; out_ready = 0;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL flush_count got=%0d want=0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
    in_pc = 32'h100; in_instr = 32'h00000013;
    #2;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL no_bypass got=%b want=0", out_valid); end
    step();
    in_valid = 0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin failures++; $display("FAIL flush_repush got=%b/%h want=1/100", out_valid, out_pc); end
    $display("test_flush done");
  endtask

  task automatic test_misaligned();
    do_reset();
    in_valid = 1; in_pc = 32'hFFFFFFFE; in_instr = $urandom;
    step();
    in_pc = 32'h8;
    step();
    in_valid = 0;
    checks++; if (out_misaligned !== 1'b1) begin failures++; $display("FAIL misaligned_flag got=%b want=1", out_misaligned); end
    checks++; if (out_pcplus4 !== 32'h2) begin failures++; $display("FAIL misaligned_pcplus4 got=%h want=2", out_pcplus4); end
    out_ready = 1;
    step();
    out_ready = 0;
    checks++; if (out_misaligned !== 1'b0) begin failures++; $display("FAIL aligned_flag got=%b want=0", out_misaligned); end
    $display("test_misaligned done");
  endtask

  task automatic test_mid_reset();
    do_reset();
    in_valid = 1;
    for (int i = 0; i < 2; i++) begin
      in_pc = 32'h40 + 32'(i * 4); in_instr = $urandom;
      step();
    end
    rst = 1; out_ready = 1; in_pc = 32'h80;
    step();
    idle_inputs();
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL midrst_count got=%0d want=0", count); end
    checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL midrst_out_pc got=%h want=0", out_pc); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    $display("test_mid_reset done");
  endtask

  task automatic test_random();
    logic [31:0] exp_pc, exp_instr;
    int bad;
    do_reset();
    bad = 0;
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 99) == 0);
      flush     = ($urandom_range(0, 24) == 0);
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 50);
      in_pc     = $urandom;
      in_instr  = $urandom;
      step();
      exp_pc    = (mq.size() > 0) ? mq[0].pc : last_head.pc;
      exp_instr = (mq.size() > 0) ? mq[0].instr : last_head.instr;
      checks++;
      if (count !== 3'(mq.size()) || out_valid !== (mq.size() != 0) ||
          in_ready !== (mq.size() != DEPTH) || out_pc !== exp_pc ||
          out_instr !== exp_instr || out_pcplus4 !== exp_pc + 32'd4 ||
          out_misaligned !== (exp_pc[1:0] != 2'b00)) begin
        failures++; bad++;
        if (bad <= 10)
          $display("FAIL random_cycle%0d got cnt=%0d v=%b r=%b pc=%h ins=%h mis=%b want cnt=%0d pc=%h ins=%h",
                   n, count, out_valid, in_ready, out_pc, out_instr, out_misaligned,
                   mq.size(), exp_pc, exp_instr);
      end
    end
    idle_inputs();
    $display("test_random done");
  endtask

  initial begin
    idle_inputs();
    last_head = '{pc: 32'h0, instr: 32'h0};
    test_reset();
    test_fill_drain();
    test_back_to_back();
    test_flush();
    test_misaligned();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the address and instruction width.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving the number of entries; it SHALL be a power of two and at least 2.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL update on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, a synchronous active-high reset.
REQ-005 The block SHALL have port flush, input, 1 bit, which discards all queued entries; it is driven on a taken branch or jump redirect.
REQ-006 The block SHALL have port in_valid, input, 1 bit, meaning the fetch side presents an entry.
REQ-007 The block SHALL have port in_pc, input, WIDTH bits, the address of the fetched instruction.
REQ-008 The block SHALL have port in_instr, input, WIDTH bits, the instruction word.
REQ-009 The block SHALL have port in_ready, output, 1 bit, meaning the queue can accept an entry this cycle.
REQ-010 The block SHALL have port out_valid, output, 1 bit, meaning a head entry is available to decode.
REQ-011 The block SHALL have port out_pc, output, WIDTH bits, the head entry address.
REQ-012 The block SHALL have port out_pcplus4, output, WIDTH bits, equal to out_pc+4 modulo 2^WIDTH.
REQ-013 The block SHALL have port out_instr, output, WIDTH bits, the head entry instruction.
REQ-014 The block SHALL have port out_misaligned, output, 1 bit, set when bits [1:0] of the head entry address are non-zero.
REQ-015 The block SHALL have port out_ready, input, 1 bit, meaning decode consumes the head entry this cycle.
REQ-016 The block SHALL have port count, output, $clog2(DEPTH)+1 bits, the number of occupied entries.

Function
REQ-017 A push SHALL occur when in_valid && in_ready && !flush.
REQ-018 A pop SHALL occur when out_valid && out_ready && !flush.
REQ-019 in_ready SHALL equal (count != DEPTH), decoded from registered state only; there is no combinational path from out_ready.
REQ-020 out_valid SHALL equal (count != 0); out_pc, out_instr, out_pcplus4 and out_misaligned SHALL be driven combinationally from the head entry.
REQ-021 An entry pushed in cycle N SHALL be visible at the outputs in cycle N+1; the minimum latency is 1 and there is no input-to-output bypass.
REQ-022 Entries SHALL be delivered in push order; the write and read pointers SHALL wrap from DEPTH-1 to 0.
REQ-023 A simultaneous push and pop SHALL leave count unchanged and advance both pointers; this SHALL be legal at any occupancy between 1 and DEPTH-1.
REQ-024 When full, in_valid SHALL be ignored and no entry SHALL be overwritten, even when a pop occurs in the same cycle.
REQ-025 When empty, out_ready SHALL be ignored and count SHALL NOT underflow.
REQ-026 flush SHALL have priority over push and pop: on the next edge count and both pointers SHALL become 0, and the entry presented that cycle SHALL be dropped.
REQ-027 While out_valid=0, out_pc, out_instr and out_pcplus4 SHALL hold their last values; they are don't-care for decode.

Reset
REQ-028 When rst=1 at a rising edge, count and both pointers SHALL become 0 and all storage entries SHALL be cleared to 0.
REQ-029 After reset, out_valid SHALL be 0, in_ready SHALL be 1, out_pc SHALL be 0, out_instr SHALL be 0 and out_pcplus4 SHALL be 4.
REQ-030 rst SHALL override flush, push and pop in the same cycle, and asserting rst mid-stream SHALL discard all entries.

Structure
REQ-031 Package fetch_pkg SHALL hold the WIDTH default, the constant NOP_INSTR = 32'h00000013, and the packed struct fetch_entry_t {pc, instr}.
REQ-032 The storage SHALL be an inline array of fetch_entry_t with no sub-module; the pointers and count logic SHALL be written inline.

Verification
REQ-033 Reset then push 3 entries (pc 0x0, 0x4, 0x8) with out_ready=0 -> count=3, out_pc=0x0, out_pcplus4=0x4, in_ready=1.
REQ-034 Push 4 entries, then hold in_valid=1 -> in_ready=0, count stays 4; pop 4 entries -> order 0x0, 0x4, 0x8, 0xC, then out_valid=0.
REQ-035 Push and pop every cycle for 10 cycles starting at count=2 -> count stays 2; pointers wrap; out_pc sequence is contiguous +4.
REQ-036 At count=3, assert flush with in_valid=1 and out_ready=1 -> next cycle count=0, out_valid=0; the next push of pc 0x100 appears one cycle later.
REQ-037 Push pc 0xFFFFFFFE -> out_misaligned=1, out_pcplus4=0x00000002.
REQ-038 Assert rst at count=2 with a push pending -> next cycle count=0, out_pc=0, in_ready=1.
